// File: rtl/rv32i_defs.sv
// Shared RV32I definitions used by the fetch path.
package rv32i_defs;

    localparam int InstructionSize = 32;
    localparam int InstrAlignBytes = 4;

    typedef struct packed {
        logic [31:0]                pc;
        logic [InstructionSize-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, instr} pairs. The head is read straight from
// registered storage, so the outputs carry no combinational input dependency.
module fetch_fifo
    import rv32i_defs::*;
#(
    parameter  int DEPTH = 2,
    localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  fetch_entry_t    wdata,
    output fetch_entry_t    rdata,
    output logic            empty,
    output logic            full,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem_reg [DEPTH];
    logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntW-1:0] count_reg, count_next;

    // Explicit wrap keeps non-power-of-two depths legal.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && !flush && (wr_ptr_reg == PtrW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_next = count_reg + CntW'(1);
                2'b01:   count_next = count_reg - CntW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rdata = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CntW'(DEPTH));
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// queues {pc, instr} pairs for decode. Redirects flush; bad PCs raise a sticky fault.
module fetch_unit
    import rv32i_defs::*;
#(
    parameter  int          N_INSTR   = 32,
    parameter  int          BUF_DEPTH = 2,
    parameter  logic [31:0] RESET_PC  = 32'h0000_0000,
    localparam int          AddrSize  = $clog2(N_INSTR * 4)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [AddrSize-1:0]        imem_addr,
    input  logic [InstructionSize-1:0] imem_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [InstructionSize-1:0] out_instr,
    output logic [31:0]                out_pc,
    output logic                       fault
);

    localparam int          CntW     = $clog2(BUF_DEPTH + 1);
    localparam int          AlignW   = $clog2(InstrAlignBytes);
    localparam logic [31:0] MemBytes = 32'(N_INSTR * InstrAlignBytes);

    logic [31:0]     pc_reg, pc_next;
    logic            fault_reg, fault_next;
    logic            pc_ok, push, pop;
    logic            fifo_empty, fifo_full;
    logic [CntW-1:0] fifo_count_unused;
    fetch_entry_t    wr_entry, head_entry;

    // Full 32-bit compare so high PC bits can't alias back into the memory.
    assign pc_ok = (pc_reg[AlignW-1:0] == '0) && (pc_reg < MemBytes);
    assign pop   = out_valid && out_ready;
    assign push  = pc_ok && !fault_reg && !redirect_valid && (!fifo_full || pop);

    always_comb begin
        pc_next    = pc_reg;
        fault_next = fault_reg;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            fault_next = 1'b0;
        end else begin
            if (push)   pc_next    = pc_reg + 32'(InstrAlignBytes);
            if (!pc_ok) fault_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            fault_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            fault_reg <= fault_next;
        end
    end

    assign wr_entry.pc    = pc_reg;
    assign wr_entry.instr = imem_instr;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count_unused)
    );

    assign imem_addr = pc_reg[AddrSize-1:0];
    assign out_valid = !fifo_empty;
    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, fault and async reset.
module tb_fetch_unit;
    import rv32i_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .N_INSTR   (32),
        .BUF_DEPTH (2),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    // Instruction memory model: known program words, filler elsewhere.
    function automatic logic [31:0] mem_word(input logic [6:0] a);
        case (a)
            7'h00:   mem_word = 32'h00500113;
            7'h04:   mem_word = 32'h00C00193;
            7'h08:   mem_word = 32'hFF718393;
            7'h18:   mem_word = 32'h02728863;
            default: mem_word = 32'hC0DE_0000 | 32'(a);
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, out_instr, instr);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = ready;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.pc", out_pc, 32'h0);
        check("rst.instr", out_instr, 32'h0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.addr", 32'(imem_addr), 32'h0);
        rst = 1'b0;

        // Streaming with out_ready high: one per cycle, no bubbles
        step(); expect_out("s0", 32'h0, 32'h00500113);
        step(); expect_out("s1", 32'h4, 32'h00C00193);
        step(); expect_out("s2", 32'h8, 32'hFF718393);

        // Backpressure: fill and hold
        do_reset(1'b0);
        repeat (5) step();
        check("bp.valid", 32'(out_valid), 32'd1);
        check("bp.pc", out_pc, 32'h0);
        check("bp.addr", 32'(imem_addr), 32'h08);
        out_ready = 1'b1;
        expect_out("bp0", 32'h0, 32'h00500113);
        step(); expect_out("bp1", 32'h4, 32'h00C00193);
        step(); expect_out("bp2", 32'h8, 32'hFF718393);

        // Redirect while full, with a pop in the redirect cycle
        do_reset(1'b0);
        step(); step();
        check("rf.addr", 32'(imem_addr), 32'h08);
        check("rf.head", out_pc, 32'h0);
        out_ready = 1'b1;
        redirect_to(32'h18);
        check("rd.valid0", 32'(out_valid), 32'd0);
        check("rd.addr", 32'(imem_addr), 32'h18);
        step(); expect_out("rd", 32'h18, 32'h02728863);

        // Run off the end of memory
        redirect_to(32'h70);
        check("end.valid0", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out($sformatf("end%0d", i), 32'h70 + 32'(4 * i), mem_word(7'(32'h70 + 32'(4 * i))));
            check($sformatf("end%0d.fault", i), 32'(fault), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("oor%0d.valid", i), 32'(out_valid), 32'd0);
            check($sformatf("oor%0d.fault", i), 32'(fault), 32'd1);
        end
        redirect_to(32'h0);
        check("rec0.fault", 32'(fault), 32'd0);
        check("rec0.valid", 32'(out_valid), 32'd0);
        step(); expect_out("rec0", 32'h0, 32'h00500113);

        // Misaligned redirect
        redirect_to(32'h6);
        check("mis.fault0", 32'(fault), 32'd0);
        check("mis.valid0", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mis%0d.fault", i), 32'(fault), 32'd1);
            check($sformatf("mis%0d.valid", i), 32'(out_valid), 32'd0);
        end
        redirect_to(32'h4);
        check("rec4.fault", 32'(fault), 32'd0);
        check("rec4.valid", 32'(out_valid), 32'd0);
        step(); expect_out("rec4", 32'h4, 32'h00C00193);

        // Asynchronous reset mid-stream with two entries buffered
        out_ready = 1'b0;
        redirect_to(32'h0);
        step(); step();
        check("ar.addr_full", 32'(imem_addr), 32'h08);
        check("ar.valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.fault", 32'(fault), 32'd0);
        check("ar.pc", out_pc, 32'h0);
        check("ar.addr", 32'(imem_addr), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        step(); expect_out("ar0", 32'h0, 32'h00500113);
        step(); expect_out("ar1", 32'h4, 32'h00C00193);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequences the combinational-read instr_memory for the RV32I core.
- Owns the fetch PC and issues one instruction-memory address per cycle.
- Buffers {pc, instr} pairs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing, and flags out-of-range or misaligned fetch PCs.

Parameters:
- N_INSTR, 32: instruction memory depth in words. Memory size is N_INSTR*4 bytes; AddrSize = $clog2(N_INSTR*4).
- BUF_DEPTH, 2: prefetch FIFO entries. Must be at least 1.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  AddrSize  byte address to instr_memory; equals pc[AddrSize-1:0]
- imem_instr  in  InstructionSize  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  load a new PC and flush the buffer
- redirect_pc  in  32  target PC for a redirect
- out_valid  out  1  buffer head is valid
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  InstructionSize  head instruction
- out_pc  out  32  PC of the head instruction
- fault  out  1  sticky fetch fault (misaligned or out-of-range PC)

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; FIFO empty (count = 0, pointers = 0); fault = 0.
  - out_valid = 0; out_instr = 0; out_pc = 0; imem_addr = RESET_PC[AddrSize-1:0].
- pc_ok = (pc[1:0] == 0) && (pc < N_INSTR*4). The compare is done at 32-bit width so that no truncation aliasing occurs.
- push = pc_ok && !fault && !redirect_valid && (count < BUF_DEPTH || pop).
- pop = out_valid && out_ready.
- On push:
  - FIFO writes {pc, imem_instr}.
  - pc <= pc + 4 (32-bit wrap is irrelevant because pc_ok gates it).
- Simultaneous push and pop when full is allowed; count is unchanged.
- Latency:
  - The instruction at pc appears at out_valid/out_pc/out_instr one cycle after the cycle in which imem_addr = pc.
  - With out_ready held high, sustained throughput is 1 instruction per cycle.
- Outputs are driven from FIFO head registers. There is no combinational path from out_ready or redirect_valid to out_valid.
- Backpressure: while full and !pop, pc and imem_addr hold.
- Redirect (priority over everything except reset):
  - At the clock edge: FIFO flushed (count = 0), pc <= redirect_pc, fault <= 0, no push that cycle.
  - A pop in the redirect cycle is still a completed handshake. Decode is responsible for discarding it.
  - The first instruction from the target is valid in the cycle after the one following the redirect cycle. Redirect penalty: 2 cycles to out_valid.
- Fault:
  - When !pc_ok && !redirect_valid, fault <= 1 at the next edge.
  - Fault is sticky until the next redirect or reset.
  - While fault = 1, no pushes occur. Already-buffered entries still drain normally.
- Pointer arithmetic:
  - rd/wr pointers are $clog2(BUF_DEPTH) bits with explicit wrap at BUF_DEPTH (non-power-of-2 legal).
  - count is $clog2(BUF_DEPTH+1) bits.

Decomposition:
- rv32i_defs: reuse InstructionSize.
- Add to rv32i_defs:
  - typedef fetch_entry_t = struct packed {logic [31:0] pc; logic [InstructionSize-1:0] instr;}.
  - localparam InstrAlignBytes = 4.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Ports: clk, rst, flush, push, pop, wdata, rdata, empty, full, count.
  - Parameter DEPTH.
- fetch_unit contains only the PC register, push/fault logic and instantiation of fetch_fifo.

Test Plan:
- Use instr_memory with N_INSTR=32 loaded with test-core.mem.
- Reset then release with out_ready=1:
  - First handshake: out_pc=0x0, out_instr=0x00500113.
  - Next cycle: 0x4/0x00C00193, then 0x8/0xFF718393.
  - No bubbles.
- Hold out_ready=0 for 5 cycles after reset:
  - count reaches 2; imem_addr holds at 0x08; out_pc stays 0x0.
  - On release, PCs 0x0, 0x4, 0x8 arrive on consecutive cycles with no gaps or duplicates.
- Redirect to 0x18 while the buffer is full (heads 0x0, 0x4):
  - Flushed PCs never appear after the redirect-cycle pop.
  - Next valid output is out_pc=0x18, out_instr=0x02728863.
- Run sequentially past the end of memory:
  - Last output is out_pc=0x7C; fault rises the cycle after pc=0x80; out_valid stays 0 once drained.
  - Redirect to 0x0 clears fault and yields 0x00500113.
- Redirect to 0x6 (misaligned):
  - fault=1 one cycle after the redirect edge; out_valid never asserts until a redirect to 0x4 recovers (0x00C00193).
- Assert rst asynchronously mid-stream (between clock edges, buffer holding 2 entries):
  - out_valid=0 and fault=0 immediately.
  - After release, the sequence restarts at out_pc=0x0.
